// File: rtl/dsp_simd_bist.sv
// dsp_simd_bist: LFSR-driven self-test that feeds a dual-lane 10x9 unsigned multiplier and checks its products
module dsp_simd_bist #(
  parameter int          NUM_VECTORS = 256,
  parameter int          LATENCY     = 1,
  parameter logic [31:0] SEED        = 32'h0000_0001
) (
  input  logic        clock_i,
  input  logic        reset_n_i,
  input  logic        start_i,
  output logic [9:0]  a0_o,
  output logic [9:0]  a1_o,
  output logic [8:0]  b0_o,
  output logic [8:0]  b1_o,
  input  logic [18:0] z0_i,
  input  logic [18:0] z1_i,
  output logic        busy_o,
  output logic        done_o,
  output logic        pass_o,
  output logic [15:0] err_count_o,
  output logic [15:0] first_fail_idx_o
);
  localparam logic [31:0] SEED_INIT = (SEED == 32'd0) ? 32'd1 : SEED;
  localparam logic [31:0] MASK = 32'h8020_0003;
  localparam logic [15:0] LAST = 16'(NUM_VECTORS - 1);
  typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;
  state_t state, state_nx;
  logic go, launch, mis0, mis1;
  logic [31:0] lfsr, src, src_nx;
  logic [15:0] idx, idx_nx;
  logic [18:0] p0, p1;
  logic [16:0] err_sum;
  logic [LATENCY:0] vld;
  logic [LATENCY:0][18:0] exp0, exp1;
  logic [LATENCY:0][15:0] vidx;
  assign go = (state == IDLE || state == DONE) && start_i;
  assign launch = go || (state == RUN && idx != LAST);
  assign src = go ? SEED_INIT : lfsr;
  assign src_nx = src[0] ? (src >> 1) ^ MASK : src >> 1;
  assign idx_nx = go ? 16'd0 : idx + 16'd1;
  assign p0 = 19'(src[9:0]) * 19'(src[18:10]);
  assign p1 = 19'(src[28:19]) * 19'({src[31:29], src[5:0]});
  assign mis0 = vld[LATENCY] && (z0_i !== exp0[LATENCY]);
  assign mis1 = vld[LATENCY] && (z1_i !== exp1[LATENCY]);
  assign err_sum = {1'b0, err_count_o} + 17'(mis0) + 17'(mis1);
  assign busy_o = state == RUN || state == DRAIN;
  assign done_o = state == DONE;
  assign pass_o = done_o && err_count_o == 16'd0;
  always_comb begin
    state_nx = go ? RUN :
               (state == RUN && idx == LAST) ? DRAIN :
               (state == DRAIN && !(|vld)) ? DONE : state;
  end
  always_ff @(posedge clock_i) begin
    if (!reset_n_i) state <= IDLE;
    else state <= state_nx;
  end
  always_ff @(posedge clock_i) begin
    exp0 <= {exp0[LATENCY-1:0], p0};
    exp1 <= {exp1[LATENCY-1:0], p1};
    vidx <= {vidx[LATENCY-1:0], idx_nx};
    if (!reset_n_i) begin
      lfsr <= SEED_INIT;
      idx <= 16'd0;
      vld <= '0;
      a0_o <= '0;
      b0_o <= '0;
      a1_o <= '0;
      b1_o <= '0;
      err_count_o <= 16'd0;
      first_fail_idx_o <= 16'hFFFF;
    end else begin
      vld <= {vld[LATENCY-1:0], launch};
      a0_o <= launch ? src[9:0] : '0;
      b0_o <= launch ? src[18:10] : '0;
      a1_o <= launch ? src[28:19] : '0;
      b1_o <= launch ? {src[31:29], src[5:0]} : '0;
      if (go || state == RUN) lfsr <= src_nx;
      if (launch) idx <= idx_nx;
      if (go) begin
        err_count_o <= 16'd0;
        first_fail_idx_o <= 16'hFFFF;
      end else if (mis0 || mis1) begin
        err_count_o <= err_sum[16] ? 16'hFFFF : err_sum[15:0];
        if (first_fail_idx_o == 16'hFFFF) first_fail_idx_o <= vidx[LATENCY];
      end
    end
  end
endmodule
